// File: rtl/spi_lb_arb_if.sv
// spi_lb_arb_if: requester-side and local-bus-side signals of the SPI local-bus arbiter.
//   REQ_*  : per-requester level requests, packed command fields, ACK/ERR pulses, shared read data
//   LB_*   : level request and command to the SPI master, its read data and one-cycle ACK
//   BUSY   : arbiter not idle; GNT_ID: current or most recent grant
//   modport slave  : the arbiter
//   modport master : the environment (requesters plus SPI master)
interface spi_lb_arb_if #(
    parameter int P_NUM_REQ    = 4,
    parameter int P_ADDR_WIDTH = 15,
    parameter int P_DATA_WIDTH = 16,
    parameter int P_ID_WIDTH   = 2
);
    logic [P_NUM_REQ-1:0]              REQ_REQ;
    logic [P_NUM_REQ-1:0]              REQ_RNW;
    logic [P_NUM_REQ*P_ADDR_WIDTH-1:0] REQ_ADR;
    logic [P_NUM_REQ*P_DATA_WIDTH-1:0] REQ_WDAT;
    logic [P_NUM_REQ-1:0]              REQ_ACK;
    logic [P_NUM_REQ-1:0]              REQ_ERR;
    logic [P_DATA_WIDTH-1:0]           REQ_RDAT;
    logic                              LB_REQ;
    logic                              LB_RNW;
    logic [P_ADDR_WIDTH-1:0]           LB_ADR;
    logic [P_DATA_WIDTH-1:0]           LB_WDAT;
    logic [P_DATA_WIDTH-1:0]           LB_RDAT;
    logic                              LB_ACK;
    logic                              BUSY;
    logic [P_ID_WIDTH-1:0]             GNT_ID;

    modport slave (
        input  REQ_REQ, REQ_RNW, REQ_ADR, REQ_WDAT, LB_RDAT, LB_ACK,
        output REQ_ACK, REQ_ERR, REQ_RDAT, LB_REQ, LB_RNW, LB_ADR, LB_WDAT, BUSY, GNT_ID
    );

    modport master (
        output REQ_REQ, REQ_RNW, REQ_ADR, REQ_WDAT, LB_RDAT, LB_ACK,
        input  REQ_ACK, REQ_ERR, REQ_RDAT, LB_REQ, LB_RNW, LB_ADR, LB_WDAT, BUSY, GNT_ID
    );
endinterface

// File: rtl/spi_lb_arb.sv
// spi_lb_arb: round-robin arbiter sharing one SPI local-bus master among P_NUM_REQ requesters.
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : spi_lb_arb_if.slave carrying requester commands/acks and the master's local bus
// Each grant runs IDLE -> WAIT (until LB_ACK or watchdog) -> GAP -> IDLE, which keeps
// LB_REQ low for at least two cycles so the master always sees a fresh rising edge.
module spi_lb_arb #(
    parameter int P_NUM_REQ    = 4,
    parameter int P_ADDR_WIDTH = 15,
    parameter int P_DATA_WIDTH = 16,
    parameter int P_TMO_WIDTH  = 12,
    parameter int P_ID_WIDTH   = 2
) (
    input logic          CLK,
    input logic          RST,
    spi_lb_arb_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_WAIT = 3'b010,
        S_GAP  = 3'b100
    } state_t;

    localparam logic [P_NUM_REQ-1:0]   ONE      = {{(P_NUM_REQ-1){1'b0}}, 1'b1};
    // last value before all-ones: the counter reaches all-ones on this cycle's edge
    localparam logic [P_TMO_WIDTH-1:0] TMO_LAST = ~P_TMO_WIDTH'(1);
    localparam logic [P_ID_WIDTH-1:0]  LAST_RST = P_ID_WIDTH'(P_NUM_REQ - 1);

    state_t                  state_q;
    logic [P_ID_WIDTH-1:0]   last_q;
    logic [P_ID_WIDTH-1:0]   gnt_q;
    logic [P_TMO_WIDTH-1:0]  wdt_q;
    logic                    lb_req_q;
    logic                    lb_rnw_q;
    logic [P_ADDR_WIDTH-1:0] lb_adr_q;
    logic [P_DATA_WIDTH-1:0] lb_wdat_q;
    logic [P_NUM_REQ-1:0]    ack_q;
    logic [P_NUM_REQ-1:0]    err_q;
    logic [P_DATA_WIDTH-1:0] rdat_q;
    logic                    busy_q;

    logic [P_ID_WIDTH-1:0]   win_d;
    logic [P_ID_WIDTH-1:0]   idx;
    logic [P_NUM_REQ-1:0]    gnt_oh;
    logic                    tmo;
    logic [P_ADDR_WIDTH-1:0] adr_a  [P_NUM_REQ];
    logic [P_DATA_WIDTH-1:0] wdat_a [P_NUM_REQ];

    for (genvar i = 0; i < P_NUM_REQ; i++) begin : g_unpack
        assign adr_a[i]  = bus.REQ_ADR[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        assign wdat_a[i] = bus.REQ_WDAT[i*P_DATA_WIDTH +: P_DATA_WIDTH];
    end

    // Scan from farthest to nearest after last grant so the nearest requester wins.
    always_comb begin
        win_d = last_q;
        idx   = '0;
        for (int k = P_NUM_REQ; k >= 1; k--) begin
            idx = P_ID_WIDTH'((int'(last_q) + k) % P_NUM_REQ);
            if (bus.REQ_REQ[idx]) win_d = idx;
        end
    end

    assign gnt_oh = ONE << gnt_q;
    assign tmo    = (wdt_q == TMO_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_RST;
            gnt_q     <= '0;
            wdt_q     <= '0;
            lb_req_q  <= 1'b0;
            lb_rnw_q  <= 1'b0;
            lb_adr_q  <= '0;
            lb_wdat_q <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdat_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (|bus.REQ_REQ) begin
                    gnt_q     <= win_d;
                    last_q    <= win_d;
                    lb_rnw_q  <= bus.REQ_RNW[win_d];
                    lb_adr_q  <= adr_a[win_d];
                    lb_wdat_q <= wdat_a[win_d];
                    lb_req_q  <= 1'b1;
                    wdt_q     <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    wdt_q <= wdt_q + 1'b1;
                    // LB_ACK takes priority over a coincident watchdog expiry
                    if (bus.LB_ACK || tmo) begin
                        lb_req_q <= 1'b0;
                        ack_q    <= gnt_oh;
                        err_q    <= bus.LB_ACK ? '0 : gnt_oh;
                        rdat_q   <= !bus.LB_ACK ? '1 : lb_rnw_q ? bus.LB_RDAT : rdat_q;
                        state_q  <= S_GAP;
                    end
                end
                S_GAP: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    lb_req_q <= 1'b0;
                    ack_q    <= '0;
                    err_q    <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.LB_REQ   = lb_req_q;
    assign bus.LB_RNW   = lb_rnw_q;
    assign bus.LB_ADR   = lb_adr_q;
    assign bus.LB_WDAT  = lb_wdat_q;
    assign bus.REQ_ACK  = ack_q;
    assign bus.REQ_ERR  = err_q;
    assign bus.REQ_RDAT = rdat_q;
    assign bus.BUSY     = busy_q;
    assign bus.GNT_ID   = gnt_q;
endmodule
